spi_reg_peripheral: RTL and testbench

SPI-mode-0 write-only responder that produces the PWM configuration registers consumed by the PWM peripheral: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. It sits in the top level between the ui_in pins (SCLK, COPI, nCS) and the PWM peripheral's register inputs. The SPI signals are asynchronous to clk and are oversampled through synchronizers. A register is committed only when a complete, valid 16-bit write frame ends.

---
 rtl/spi_reg_pkg.sv | 45 ++++
 rtl/spi_reg_peripheral_sync_edge.sv | 47 ++++
 rtl/spi_reg_peripheral.sv | 146 ++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM state type for the SPI register
// responder that configures the PWM peripheral.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;
    localparam int COUNT_BITS = 5;
    localparam int NUM_REGS   = 5;

    // The bit counter stops one past a full frame so that any overlong
    // frame stays distinguishable from an exact 16-bit frame.
    localparam logic [COUNT_BITS-1:0] COUNT_FULL = COUNT_BITS'(FRAME_BITS);
    localparam logic [COUNT_BITS-1:0] COUNT_SAT  = COUNT_BITS'(FRAME_BITS + 1);

    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Shift register contents in transmit order: R/W, address, data.
    typedef struct packed {
        logic                 rw;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

    // A frame is written only if it is exactly FRAME_BITS long, is a
    // write, and targets an address no higher than max_addr.
    function automatic logic frame_writes(
        input frame_t                  frame,
        input logic [COUNT_BITS-1:0]   count,
        input logic [ADDR_BITS-1:0]    max_addr
    );
        return (count == COUNT_FULL) && frame.rw && (frame.addr <= max_addr);
    endfunction

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus a history flop
// that yields single-cycle rise and fall strobes in the clk domain.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Next values: shift the pin into the chain, remember the last synced level.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // trivially); a missed branch would infer a latch.
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the chain resets to 0 so that a chip select already low when
        // reset releases produces no falling edge, and no frame starts until
        // it has been seen high first.
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge value of its neighbour.
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0, write-only responder holding the five PWM configuration
// registers. SPI pins are oversampled in the clk domain; a register is
// written only after a complete, valid 16-bit write frame ends.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter logic [ADDR_BITS-1:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    // Synchronized pin views and edge strobes.
    logic sclk_level, sclk_rise, sclk_fall;
    logic ncs_level,  ncs_rise,  ncs_fall;
    logic copi_level, copi_rise, copi_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .din   (ncs),
        .level (ncs_level),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .din   (copi),
        .level (copi_level),
        .rise  (copi_rise),
        .fall  (copi_fall)
    );

    // Only the SCLK rising edge, the nCS edges and the COPI level matter.
    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_level, sclk_fall, ncs_level, copi_rise, copi_fall};

    // FSM, frame shifter and register file state.
    state_e                state_q,  state_d;
    logic [FRAME_BITS-1:0] shift_q,  shift_d;
    logic [COUNT_BITS-1:0] count_q,  count_d;
    logic [DATA_BITS-1:0]  regs_q [NUM_REGS];
    logic [DATA_BITS-1:0]  regs_d [NUM_REGS];

    frame_t frame;
    assign frame = frame_t'(shift_q);

    // Next-state, shift and commit decisions.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            IDLE: begin
                // Shifter is held clear; SCLK activity here is ignored.
                shift_d = '0;
                count_d = '0;
                if (ncs_fall) begin
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // End of frame wins over a coincident SCLK edge, which is
                // therefore not counted.
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_level};
                    count_d = (count_q == COUNT_SAT) ? count_q : count_q + 1'b1;
                end
            end

            COMMIT: begin
                if (frame_writes(frame, count_q, MAX_ADDR)) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (frame.addr == ADDR_BITS'(i)) begin
                            regs_d[i] = frame.data;
                        end
                    end
                end
                shift_d = '0;
                count_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                shift_d = '0;
                count_d = '0;
            end
        endcase
    end

    // Single state register for the FSM, shifter and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            // NOTE: this small register file drives live configuration
            // outputs, so unlike a RAM every entry must be reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed, table-driven bench for spi_reg_peripheral with hand-written
// sequences for commit latency, back-to-back frames, mid-frame reset and
// SCLK activity while deselected.
module tb_spi_reg_peripheral;

    localparam int HALF = 4;  // clk periods per SCLK phase (minimum is 3)

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    int tests_run    = 0;
    int tests_failed = 0;

    spi_reg_peripheral #(
        .SYNC_STAGES (2),
        .MAX_ADDR    (7'h04)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    // Expected register image packed as {out_lo, out_hi, pwm_lo, pwm_hi, duty}.
    typedef struct packed {
        logic [31:0] bits;
        logic [7:0]  nbits;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [39:0] e);
        check({tag, " en_reg_out_7_0"},  en_reg_out_7_0,  e[39:32]);
        check({tag, " en_reg_out_15_8"}, en_reg_out_15_8, e[31:24]);
        check({tag, " en_reg_pwm_7_0"},  en_reg_pwm_7_0,  e[23:16]);
        check({tag, " en_reg_pwm_15_8"}, en_reg_pwm_15_8, e[15:8]);
        check({tag, " pwm_duty_cycle"},  pwm_duty_cycle,  e[7:0]);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock out the low n bits of 'bits', MSB first, mode 0.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    // Full frame with chip select, followed by 'gap' clk periods of nCS high.
    task automatic spi_frame(input logic [31:0] bits, input int n, input int gap);
        ncs = 1'b0;
        wait_clks(HALF);
        send_bits(bits, n);
        wait_clks(HALF);
        ncs = 1'b1;
        wait_clks(gap);
    endtask

    initial begin
        vecs[0] = '{32'h0000_80FF, 8'd16, 40'hFF_00_00_00_00};  // write addr 0
        vecs[1] = '{32'h0000_8480, 8'd16, 40'hFF_00_00_00_80};  // write duty
        vecs[2] = '{32'h0000_8512, 8'd16, 40'hFF_00_00_00_80};  // addr 5: dropped
        vecs[3] = '{32'h0000_0012, 8'd16, 40'hFF_00_00_00_80};  // read: dropped
        vecs[4] = '{32'h0000_FF11, 8'd16, 40'hFF_00_00_00_80};  // addr 0x7F: dropped
        vecs[5] = '{32'h0000_40AA, 8'd15, 40'hFF_00_00_00_80};  // 0x8155 cut to 15 bits
        vecs[6] = '{32'h0001_02AB, 8'd17, 40'hFF_00_00_00_80};  // 0x8155 plus one bit
        vecs[7] = '{32'h0000_815A, 8'd16, 40'hFF_5A_00_00_80};  // valid after bad frames
        vecs[8] = '{32'h0000_8233, 8'd16, 40'hFF_5A_33_00_80};  // write addr 2

        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        wait_clks(3);
        check_regs("reset", 40'h0);
        rst = 1'b0;
        wait_clks(5);

        // Table-driven frames.
        for (int i = 0; i < 9; i++) begin
            spi_frame(vecs[i].bits, int'(vecs[i].nbits), 10);
            check_regs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Commit latency: unchanged after 3 edges, written at the 4th.
        ncs = 1'b0;
        wait_clks(HALF);
        send_bits(32'h8012, 16);
        wait_clks(HALF);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("latency edge3 en_reg_out_7_0", en_reg_out_7_0, 8'hFF);
        @(posedge clk);
        #1;
        check("latency edge4 en_reg_out_7_0", en_reg_out_7_0, 8'h12);
        wait_clks(10);

        // Back-to-back frames with the minimum nCS high time.
        spi_frame(32'h8466, 16, 4);
        spi_frame(32'h83A5, 16, 10);
        check_regs("b2b", 40'h12_5A_33_A5_66);

        // Reset after 8 bits of 0x8177 with nCS held low.
        ncs = 1'b0;
        wait_clks(HALF);
        send_bits(32'h81, 8);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(1);
        check_regs("midreset", 40'h0);
        send_bits(32'h77, 8);
        wait_clks(HALF);
        ncs = 1'b1;
        wait_clks(10);
        check_regs("midreset_end", 40'h0);
        spi_frame(32'h8177, 16, 10);
        check_regs("after_reset", 40'h00_77_00_00_00);

        // SCLK and COPI activity while deselected must be ignored.
        for (int i = 0; i < 6; i++) begin
            copi = i[0];
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
            wait_clks(HALF);
        end
        check_regs("idle_sclk", 40'h00_77_00_00_00);
        spi_frame(32'h82C3, 16, 10);
        check_regs("after_idle", 40'h00_77_C3_00_00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
